// File: rtl/hack_pkg.sv
// Shared encodings for the Hack run controller.
//   cmd_op_e : host command opcodes carried on cmd_op
//   state_e  : run-controller FSM states, exported on the state port
//   cause_e  : completion causes reported on done_cause
package hack_pkg;

  localparam int unsigned HACK_WORD_W = 16;

  typedef enum logic [1:0] {
    OpLoad = 2'd0,
    OpRun  = 2'd1,
    OpStep = 2'd2,
    OpStop = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRst  = 3'd2,
    StRun  = 3'd3,
    StStep = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CauseLoadOk  = 3'd0,
    CauseBudget  = 3'd1,
    CauseBreak   = 3'd2,
    CauseStopped = 3'd3,
    CauseLoadErr = 3'd4,
    CauseStepOk  = 3'd5
  } cause_e;

endpackage

// File: rtl/hack_run_ctrl_if.sv
// Signal bundle between a host/debug agent (master) and the run controller (slave).
//   cmd_*      : command handshake (op + argument)
//   ld_*       : program-word stream handshake
//   rom_*      : instruction-ROM write port
//   cpu_*      : Computer reset, clock enable and observed PC
//   bp_*       : PC breakpoint
//   state, cycles, done, done_cause : status
interface hack_run_ctrl_if #(
  parameter int unsigned ROM_AW = 15,
  parameter int unsigned CNT_W  = 32
) ();
  import hack_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [CNT_W-1:0]       cmd_arg;

  logic                   ld_valid;
  logic                   ld_ready;
  logic [HACK_WORD_W-1:0] ld_data;

  logic                   rom_we;
  logic [ROM_AW-1:0]      rom_addr;
  logic [HACK_WORD_W-1:0] rom_wdata;

  logic                   cpu_reset;
  logic                   cpu_clk_en;
  logic [HACK_WORD_W-1:0] cpu_pc;

  logic                   bp_en;
  logic [HACK_WORD_W-1:0] bp_addr;

  logic [2:0]             state;
  logic [CNT_W-1:0]       cycles;
  logic                   done;
  logic [2:0]             done_cause;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, ld_valid, ld_data, cpu_pc, bp_en, bp_addr,
    input  cmd_ready, ld_ready, rom_we, rom_addr, rom_wdata, cpu_reset, cpu_clk_en,
           state, cycles, done, done_cause
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, ld_valid, ld_data, cpu_pc, bp_en, bp_addr,
    output cmd_ready, ld_ready, rom_we, rom_addr, rom_wdata, cpu_reset, cpu_clk_en,
           state, cycles, done, done_cause
  );

endinterface

// File: rtl/hack_stop_check.sv
// Combinational halt evaluation shared by RUN and STEP.
// Priority STOP > BREAK > BUDGET; hit_o set when any condition holds, cause_o names it.
//   stop_i       : STOP command accepted this cycle
//   bp_en_i      : breakpoint enable
//   pc_i         : current Computer PC
//   bp_addr_i    : breakpoint PC
//   brk_exempt_i : suppress BREAK (first RUN cycle after RST)
//   budget_en_i  : BUDGET check active (RUN with non-zero budget)
//   cycles_i     : cycles executed so far
//   budget_i     : cycle budget
module hack_stop_check import hack_pkg::*; #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                   stop_i,
  input  logic                   bp_en_i,
  input  logic [HACK_WORD_W-1:0] pc_i,
  input  logic [HACK_WORD_W-1:0] bp_addr_i,
  input  logic                   brk_exempt_i,
  input  logic                   budget_en_i,
  input  logic [CNT_W-1:0]       cycles_i,
  input  logic [CNT_W-1:0]       budget_i,
  output logic                   hit_o,
  output cause_e                 cause_o
);

  always_comb begin
    hit_o   = 1'b1;
    cause_o = CauseStopped;
    if (stop_i) begin
      cause_o = CauseStopped;
    end else if (bp_en_i && (pc_i == bp_addr_i) && !brk_exempt_i) begin
      cause_o = CauseBreak;
    end else if (budget_en_i && (cycles_i == budget_i)) begin
      cause_o = CauseBudget;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/hack_run_ctrl.sv
// Run controller for the Hack computer: loads a program into instruction ROM, then runs,
// single-steps or halts the CPU via its reset line and per-cycle clock enable.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of hack_run_ctrl_if (commands, load stream, ROM write port,
//             CPU control, breakpoint, status)
module hack_run_ctrl import hack_pkg::*; #(
  parameter int unsigned ROM_AW = 15,
  parameter int unsigned CNT_W  = 32
) (
  input logic           clk,
  input logic           reset_n,
  hack_run_ctrl_if.slave bus
);

  // Load lengths go up to a full ROM, so one bit wider than the address.
  localparam int unsigned   LdW      = ROM_AW + 1;
  localparam logic [CNT_W:0] RomDepth = (CNT_W + 1)'(1) << ROM_AW;

  state_e           state_q, state_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic [LdW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [LdW-1:0]   ld_len_q, ld_len_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             done_q, done_d;
  cause_e           cause_q, cause_d;

  cmd_op_e op;
  logic    op_is_stop;
  logic    stop_req;
  logic    ld_fire;
  logic    ld_last;
  logic    in_exec;
  logic    brk_exempt;
  logic    budget_en;
  logic    hit;
  cause_e  hit_cause;
  logic    cpu_run;

  assign op         = cmd_op_e'(bus.cmd_op);
  assign op_is_stop = (op == OpStop);
  assign stop_req   = bus.cmd_valid && op_is_stop;
  assign ld_fire    = (state_q == StLoad) && bus.ld_valid;
  assign ld_last    = ld_fire && (ld_cnt_q == ld_len_q - LdW'(1));
  assign in_exec    = (state_q == StRun) || (state_q == StStep);
  // A breakpoint at PC 0 must not fire on the very first cycle after RST.
  assign brk_exempt = (state_q == StRun) && (cycles_q == '0);
  assign budget_en  = (state_q == StRun) && (budget_q != '0);
  // Halt conditions are checked before enabling, so a halting instruction never executes.
  assign cpu_run    = in_exec && !hit;

  hack_stop_check #(
    .CNT_W (CNT_W)
  ) u_stop_check (
    .stop_i       (stop_req),
    .bp_en_i      (bus.bp_en),
    .pc_i         (bus.cpu_pc),
    .bp_addr_i    (bus.bp_addr),
    .brk_exempt_i (brk_exempt),
    .budget_en_i  (budget_en),
    .cycles_i     (cycles_q),
    .budget_i     (budget_q),
    .hit_o        (hit),
    .cause_o      (hit_cause)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cpu_reset_q <= 1'b1;
      ld_cnt_q    <= '0;
      ld_len_q    <= '0;
      budget_q    <= '0;
      cycles_q    <= '0;
      remain_q    <= '0;
      done_q      <= 1'b0;
      cause_q     <= CauseLoadOk;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= cpu_reset_d;
      ld_cnt_q    <= ld_cnt_d;
      ld_len_q    <= ld_len_d;
      budget_q    <= budget_d;
      cycles_q    <= cycles_d;
      remain_q    <= remain_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cpu_reset_d = cpu_reset_q;
    ld_cnt_d    = ld_cnt_q;
    ld_len_d    = ld_len_q;
    budget_d    = budget_q;
    cycles_d    = cycles_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    cause_d     = cause_q;

    // Saturating count of enabled CPU cycles.
    if (cpu_run && (cycles_q != '1)) begin
      cycles_d = cycles_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          unique case (op)
            OpLoad: begin
              if ({1'b0, bus.cmd_arg} > RomDepth) begin
                done_d  = 1'b1;
                cause_d = CauseLoadErr;
              end else if (bus.cmd_arg == '0) begin
                done_d  = 1'b1;
                cause_d = CauseLoadOk;
              end else begin
                state_d     = StLoad;
                cpu_reset_d = 1'b1;
                ld_cnt_d    = '0;
                ld_len_d    = LdW'(bus.cmd_arg);
              end
            end
            OpRun: begin
              state_d  = StRst;
              budget_d = bus.cmd_arg;
              cycles_d = '0;
            end
            OpStep: begin
              state_d     = StStep;
              cpu_reset_d = 1'b0;
              remain_d    = (bus.cmd_arg == '0) ? CNT_W'(1) : bus.cmd_arg;
            end
            OpStop: ;
          endcase
        end
      end
      StLoad: begin
        if (ld_fire) begin
          ld_cnt_d = ld_cnt_q + LdW'(1);
        end
        // The final beat beats a simultaneous STOP; cmd_ready is low on that cycle.
        if (ld_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cause_d = CauseLoadOk;
        end else if (stop_req) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cause_d = CauseStopped;
        end
      end
      StRst: begin
        state_d     = StRun;
        cpu_reset_d = 1'b0;
      end
      StRun: begin
        if (hit) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cause_d = hit_cause;
        end
      end
      StStep: begin
        if (hit) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cause_d = hit_cause;
        end else begin
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            cause_d = CauseStepOk;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cmd_ready  = 1'b0;
    bus.ld_ready   = 1'b0;
    bus.rom_we     = ld_fire;
    bus.rom_addr   = ld_cnt_q[ROM_AW-1:0];
    bus.rom_wdata  = bus.ld_data;
    bus.cpu_reset  = cpu_reset_q;
    bus.cpu_clk_en = 1'b0;
    bus.state      = state_q;
    bus.cycles     = cycles_q;
    bus.done       = done_q;
    bus.done_cause = cause_q;

    unique case (state_q)
      StIdle: bus.cmd_ready = 1'b1;
      StLoad: begin
        bus.ld_ready  = 1'b1;
        bus.cmd_ready = op_is_stop && !ld_last;
      end
      StRst: begin
        // One cycle with reset and enable together so the Computer reloads PC=0.
        bus.cpu_reset  = 1'b1;
        bus.cpu_clk_en = 1'b1;
      end
      StRun, StStep: begin
        bus.cmd_ready  = op_is_stop;
        bus.cpu_clk_en = cpu_run;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hack_run_ctrl.sv
module tb_hack_run_ctrl;
  import hack_pkg::*;

  localparam int unsigned RomAw = 3;
  localparam int unsigned CntW  = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hack_run_ctrl_if #(.ROM_AW(RomAw), .CNT_W(CntW)) bus ();

  hack_run_ctrl #(.ROM_AW(RomAw), .CNT_W(CntW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Minimal Computer model: PC reloads on reset, otherwise advances on each enabled cycle.
  logic [15:0] pc = 16'h0040;
  always @(posedge clk) begin
    if (bus.cpu_clk_en) pc <= bus.cpu_reset ? 16'h0000 : pc + 16'h0001;
  end
  assign bus.cpu_pc = pc;

  typedef struct {
    logic [RomAw-1:0] addr;
    logic [15:0]      data;
  } wr_t;

  typedef struct {
    logic [2:0]  cause;
    bit          chk_cyc;
    logic [31:0] cyc;
  } done_t;

  wr_t   wr_q[$];
  done_t exp_done_q[$];

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int en_cnt = 0;
  int rst_en_cnt = 0;
  int done_seen = 0;
  int done_exp = 0;
  bit executed [0:255];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic push_done(input logic [2:0] cause, input bit chk, input logic [31:0] cyc);
    done_t d;
    d.cause   = cause;
    d.chk_cyc = chk;
    d.cyc     = cyc;
    exp_done_q.push_back(d);
    done_exp++;
  endtask

  // Monitor: scores ROM writes and completions against the queues, counts CPU cycles.
  initial begin
    wr_t   w;
    done_t d;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (bus.rom_we === 1'b1) begin
          we_cnt++;
          if (wr_q.size() == 0) begin
            fail_event("unexpected_rom_we", $sformatf("addr=0x%0h, none expected", bus.rom_addr));
          end else begin
            w = wr_q.pop_front();
            check("rom_addr", bus.rom_addr, w.addr);
            check("rom_wdata", bus.rom_wdata, w.data);
            check("load_cpu_reset", bus.cpu_reset, 1'b1);
          end
        end
        if (bus.done === 1'b1) begin
          done_seen++;
          if (exp_done_q.size() == 0) begin
            fail_event("unexpected_done", $sformatf("cause=%0d, none expected", bus.done_cause));
          end else begin
            d = exp_done_q.pop_front();
            check("done_cause", bus.done_cause, d.cause);
            if (d.chk_cyc) check("done_cycles", bus.cycles, d.cyc);
          end
        end
        if (bus.cpu_clk_en === 1'b1) begin
          if (bus.cpu_reset === 1'b1) begin
            rst_en_cnt++;
          end else begin
            en_cnt++;
            executed[pc[7:0]] = 1'b1;
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_event("cmd_timeout", $sformatf("op=%0d never accepted", op));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic ld_beat(input logic [RomAw-1:0] addr, input logic [15:0] data, input int gap);
    wr_t w;
    int  n = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    w.addr = addr;
    w.data = data;
    wr_q.push_back(w);
    bus.ld_valid = 1'b1;
    bus.ld_data  = data;
    @(negedge clk);
    while (bus.ld_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_event("ld_timeout", $sformatf("word 0x%0h never accepted", data));
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_seen < done_exp && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_seen < done_exp) fail_event("done_timeout", $sformatf("seen %0d of %0d", done_seen,
                                                                   done_exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int n;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_arg   = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.bp_en     = 1'b0;
    bus.bp_addr   = '0;

    repeat (2) @(negedge clk);
    check("rst_state", bus.state, StIdle);
    check("rst_cpu_reset", bus.cpu_reset, 1'b1);
    check("rst_cpu_clk_en", bus.cpu_clk_en, 1'b0);
    check("rst_rom_we", bus.rom_we, 1'b0);
    check("rst_ld_ready", bus.ld_ready, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_done_cause", bus.done_cause, 3'd0);
    check("rst_cycles", bus.cycles, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Gapped 4-word load.
    push_done(CauseLoadOk, 1'b0, 0);
    send_cmd(OpLoad, 32'd4);
    ld_beat(3'd0, 16'h0005, 1);
    ld_beat(3'd1, 16'hEC10, 2);
    ld_beat(3'd2, 16'h0000, 0);
    ld_beat(3'd3, 16'hE301, 3);
    @(negedge clk);
    check("load_done_latency", bus.done, 1'b1);
    wait_done();

    // Budgeted run.
    en_cnt = 0;
    rst_en_cnt = 0;
    push_done(CauseBudget, 1'b1, 32'd10);
    send_cmd(OpRun, 32'd10);
    wait_done();
    check("run_en_cycles", en_cnt, 10);
    check("run_rst_cycles", rst_en_cnt, 1);
    check("run_cpu_reset", bus.cpu_reset, 1'b0);
    check("run_pc", pc, 16'd10);
    check("run_state", bus.state, StIdle);

    // Breakpoint at PC 0 is exempt on the first cycle; budget stops it.
    bus.bp_en   = 1'b1;
    bus.bp_addr = 16'h0000;
    push_done(CauseBudget, 1'b1, 32'd3);
    send_cmd(OpRun, 32'd3);
    wait_done();
    check("bp0_pc", pc, 16'd3);

    // Unlimited run halted by breakpoint at PC 2.
    for (int i = 0; i < 256; i++) executed[i] = 1'b0;
    en_cnt = 0;
    bus.bp_addr = 16'h0002;
    push_done(CauseBreak, 1'b1, 32'd2);
    send_cmd(OpRun, 32'd0);
    wait_done();
    check("brk_pc", pc, 16'd2);
    check("brk_not_executed", executed[2], 1'b0);
    check("brk_en_cycles", en_cnt, 2);

    // Single steps.
    bus.bp_en = 1'b0;
    en_cnt = 0;
    push_done(CauseStepOk, 1'b0, 0);
    send_cmd(OpStep, 32'd1);
    wait_done();
    check("step1_en_cycles", en_cnt, 1);
    check("step1_pc", pc, 16'd3);
    check("step1_executed", executed[2], 1'b1);

    en_cnt = 0;
    push_done(CauseStepOk, 1'b0, 0);
    send_cmd(OpStep, 32'd0);
    wait_done();
    check("step0_en_cycles", en_cnt, 1);
    check("step0_pc", pc, 16'd4);

    bus.bp_en   = 1'b1;
    bus.bp_addr = 16'h0006;
    en_cnt = 0;
    push_done(CauseBreak, 1'b0, 0);
    send_cmd(OpStep, 32'd5);
    wait_done();
    check("stepbrk_en_cycles", en_cnt, 2);
    check("stepbrk_pc", pc, 16'd6);

    // Oversize load, empty load, full-ROM load.
    w0 = we_cnt;
    push_done(CauseLoadErr, 1'b0, 0);
    send_cmd(OpLoad, 32'd9);
    wait_done();
    check("loaderr_writes", we_cnt - w0, 0);
    check("loaderr_state", bus.state, StIdle);

    w0 = we_cnt;
    push_done(CauseLoadOk, 1'b0, 0);
    send_cmd(OpLoad, 32'd0);
    wait_done();
    check("load0_writes", we_cnt - w0, 0);

    w0 = we_cnt;
    push_done(CauseLoadOk, 1'b0, 0);
    send_cmd(OpLoad, 32'd8);
    for (int i = 0; i < 8; i++) ld_beat(3'(i), 16'h1000 + 16'(i), i % 2);
    wait_done();
    check("loadfull_writes", we_cnt - w0, 8);

    // STOP during a load keeps the partial program and the CPU in reset.
    w0 = we_cnt;
    push_done(CauseStopped, 1'b0, 0);
    send_cmd(OpLoad, 32'd5);
    ld_beat(3'd0, 16'hA0A0, 0);
    ld_beat(3'd1, 16'hB1B1, 0);
    send_cmd(OpStop, 32'd0);
    wait_done();
    check("loadstop_writes", we_cnt - w0, 2);
    check("loadstop_cpu_reset", bus.cpu_reset, 1'b1);
    check("loadstop_state", bus.state, StIdle);

    // STOP and breakpoint in the same cycle at cycle 7: STOP wins.
    bus.bp_en   = 1'b1;
    bus.bp_addr = 16'h0007;
    en_cnt = 0;
    push_done(CauseStopped, 1'b1, 32'd7);
    send_cmd(OpRun, 32'd0);
    n = 0;
    @(negedge clk);
    while (bus.cycles !== 32'd7 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_event("cycles7_timeout", "cycles never reached 7");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OpStop;
    bus.cmd_arg   = '0;
    #1;
    check("stopbrk_clk_en", bus.cpu_clk_en, 1'b0);
    check("stopbrk_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_done();
    check("stopbrk_en_cycles", en_cnt, 7);
    check("stopbrk_pc", pc, 16'd7);

    // Reset in the middle of a load.
    bus.bp_en = 1'b0;
    send_cmd(OpLoad, 32'd4);
    ld_beat(3'd0, 16'h1111, 0);
    ld_beat(3'd1, 16'h2222, 0);
    w0 = we_cnt;
    reset_n      = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'hDEAD;
    #1;
    check("midrst_state", bus.state, StIdle);
    check("midrst_cpu_reset", bus.cpu_reset, 1'b1);
    check("midrst_ld_ready", bus.ld_ready, 1'b0);
    check("midrst_rom_we", bus.rom_we, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    check("midrst_writes", we_cnt - w0, 0);

    w0 = we_cnt;
    push_done(CauseLoadOk, 1'b0, 0);
    send_cmd(OpLoad, 32'd2);
    ld_beat(3'd0, 16'h3333, 0);
    ld_beat(3'd1, 16'h4444, 1);
    wait_done();
    check("reload_writes", we_cnt - w0, 2);

    repeat (3) @(negedge clk);
    check("wr_queue_drained", wr_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
